// File: rtl/present_ctr_pkg.sv
// Shared types, constants and PRESENT layer helpers for the streaming CTR engine.
package present_ctr_pkg;

  localparam int ROUNDS = 31;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_RUN  = 2'd1,
    E_HOLD = 2'd2
  } eng_state_e;

  function automatic logic [63:0] s_layer(input logic [63:0] s);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = SBOX[s[4*i +: 4]];
    end
    return r;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays in place.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 63; i++) begin
      r[(16 * i) % 63] = s[i];
    end
    r[63] = s[63];
    return r;
  endfunction

  function automatic bit key_w_legal(input int kw);
    return (kw == 80) || (kw == 128);
  endfunction

endpackage

// File: rtl/present_ctr_engine.sv
// Iterative PRESENT encryptor: one round per cycle with on-the-fly key schedule,
// start/result handshake, result held in E_HOLD until the consumer is ready.
module present_ctr_engine
  import present_ctr_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [63:0]      blk_in,
  output logic             idle,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data
);

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS + 1);

  eng_state_e       state_q, state_d;
  logic [63:0]      dp_q, dp_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [5:0]       round_q, round_d;

  logic [63:0]      round_key;
  logic [63:0]      round_out;
  logic [KEY_W-1:0] key_rot;
  logic [KEY_W-1:0] key_nxt;
  logic             last_round;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= E_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_q    <= 64'd0;
      key_q   <= {KEY_W{1'b0}};
      round_q <= 6'd0;
    end else begin
      dp_q    <= dp_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  // Round function and key schedule; round_q doubles as the schedule counter.
  always_comb begin
    round_key  = key_q[KEY_W-1 -: 64];
    round_out  = p_layer(s_layer(dp_q ^ round_key));
    last_round = (round_q == LAST_ROUND);
    key_rot    = {key_q[KEY_W-62:0], key_q[KEY_W-1:KEY_W-61]};
    key_nxt    = key_rot;
    key_nxt[KEY_W-1 -: 4] = SBOX[key_rot[KEY_W-1 -: 4]];
    if (KEY_W == 128) begin
      key_nxt[KEY_W-5 -: 4] = SBOX[key_rot[KEY_W-5 -: 4]];
      key_nxt[66:62]        = key_rot[66:62] ^ round_q[4:0];
    end else begin
      key_nxt[19:15]        = key_rot[19:15] ^ round_q[4:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      E_IDLE: begin
        if (start) state_d = E_RUN;
        else       state_d = E_IDLE;
      end
      E_RUN: begin
        if (!last_round)    state_d = E_RUN;
        else if (res_ready) state_d = E_IDLE;
        else                state_d = E_HOLD;
      end
      E_HOLD: begin
        if (res_ready) state_d = E_IDLE;
        else           state_d = E_HOLD;
      end
      default: state_d = E_IDLE;
    endcase
  end

  always_comb begin
    dp_d    = dp_q;
    key_d   = key_q;
    round_d = round_q;
    case (state_q)
      E_IDLE: begin
        if (start) begin
          dp_d    = blk_in;
          key_d   = key;
          round_d = 6'd1;
        end else begin
          dp_d    = dp_q;
        end
      end
      E_RUN: begin
        if (!last_round) begin
          dp_d    = round_out;
          key_d   = key_nxt;
          round_d = round_q + 6'd1;
        end else begin
          // Keep the whitened result in case the consumer is not ready yet.
          dp_d    = dp_q ^ round_key;
        end
      end
      E_HOLD: dp_d = dp_q;
      default: begin
        dp_d    = 64'd0;
        key_d   = {KEY_W{1'b0}};
        round_d = 6'd0;
      end
    endcase
  end

  always_comb begin
    idle      = 1'b0;
    res_valid = 1'b0;
    res_data  = dp_q;
    case (state_q)
      E_IDLE: idle = 1'b1;
      E_RUN: begin
        res_valid = last_round;
        res_data  = dp_q ^ round_key;
      end
      E_HOLD: res_valid = 1'b1;
      default: idle = 1'b0;
    endcase
  end

endmodule

// File: rtl/present_ctr_stream.sv
// Streaming PRESENT counter-mode engine with valid/ready data sides.
// Optional macro PRESENT_CTR_PREFETCH_EN lets the next keystream be computed while one waits.
module present_ctr_stream
  import present_ctr_pkg::*;
#(
  parameter int KEY_W = 80,
  parameter int CTR_W = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [63:0]      iv,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  if (!key_w_legal(KEY_W) || (CTR_W < 1) || (CTR_W > 64)) begin : g_bad_param
    $error("present_ctr_stream: KEY_W must be 80 or 128 and CTR_W within 1..64");
  end

  localparam logic [63:0]      CTR_MASK = (CTR_W >= 64) ? {64{1'b1}} : ((64'd1 << CTR_W) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Only the low CTR_W bits count; the upper bits never receive a carry.
  function automatic logic [63:0] ctr_next(input logic [63:0] c);
    return (c & ~CTR_MASK) | ((c + 64'd1) & CTR_MASK);
  endfunction

  logic             busy_q, busy_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [63:0]      ctr_q, ctr_d;
  logic [CNT_W-1:0] gen_left_q, gen_left_d;
  logic [CNT_W-1:0] in_left_q, in_left_d;
  logic [63:0]      ks_q, ks_d;
  logic             ks_valid_q, ks_valid_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;

  logic             start_acc;
  logic             launch_first;
  logic             launch_run;
  logic             launch_gate;
  logic             eng_start;
  logic [KEY_W-1:0] eng_key;
  logic [63:0]      eng_blk;
  logic             eng_idle;
  logic             eng_res_valid;
  logic [63:0]      eng_res_data;
  logic             ks_load;
  logic             in_xfer;
  logic             out_xfer;

  present_ctr_engine #(
    .KEY_W (KEY_W)
  ) u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (eng_start),
    .key       (eng_key),
    .blk_in    (eng_blk),
    .idle      (eng_idle),
    .res_valid (eng_res_valid),
    .res_ready (!ks_valid_q),
    .res_data  (eng_res_data)
  );

  // Launch and handshake decode; the first block launches straight from the start inputs.
  always_comb begin
`ifdef PRESENT_CTR_PREFETCH_EN
    launch_gate  = 1'b1;
`else
    launch_gate  = !ks_valid_q && !out_valid_q;
`endif
    start_acc    = start && !busy_q;
    launch_first = start_acc && (num_blocks != CNT_ZERO);
    launch_run   = busy_q && eng_idle && (gen_left_q != CNT_ZERO) && launch_gate;
    eng_start    = launch_first || launch_run;
    eng_key      = launch_first ? key : key_q;
    eng_blk      = launch_first ? iv : ctr_q;
    ks_load      = eng_res_valid && !ks_valid_q;
    in_ready     = ks_valid_q && (!out_valid_q || out_ready);
    in_xfer      = in_valid && in_ready;
    out_xfer     = out_valid_q && out_ready;
  end

  always_comb begin
    busy_d      = busy_q;
    key_d       = key_q;
    ctr_d       = ctr_q;
    gen_left_d  = gen_left_q;
    in_left_d   = in_left_q;
    ks_d        = ks_q;
    ks_valid_d  = ks_valid_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    if (start_acc) begin
      busy_d    = 1'b1;
      key_d     = key;
      in_left_d = num_blocks;
      if (num_blocks != CNT_ZERO) begin
        ctr_d      = ctr_next(iv);
        gen_left_d = num_blocks - CNT_ONE;
      end else begin
        ctr_d      = iv;
        gen_left_d = CNT_ZERO;
      end
    end else if (launch_run) begin
      ctr_d      = ctr_next(ctr_q);
      gen_left_d = gen_left_q - CNT_ONE;
    end else begin
      ctr_d      = ctr_q;
    end

    if (ks_load) begin
      ks_d       = eng_res_data;
      ks_valid_d = 1'b1;
    end else if (in_xfer) begin
      ks_valid_d = 1'b0;
    end else begin
      ks_valid_d = ks_valid_q;
    end

    if (in_xfer) begin
      out_data_d  = in_data ^ ks_q;
      out_valid_d = 1'b1;
      out_last_d  = (in_left_q == CNT_ONE);
      in_left_d   = in_left_q - CNT_ONE;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // Nothing left to take in and nothing pending out only happens for an empty message.
    if (busy_q && ((out_xfer && out_last_q) ||
                   ((in_left_q == CNT_ZERO) && !out_valid_q))) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end else begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      key_q       <= {KEY_W{1'b0}};
      ctr_q       <= 64'd0;
      gen_left_q  <= CNT_ZERO;
      in_left_q   <= CNT_ZERO;
      ks_q        <= 64'd0;
      ks_valid_q  <= 1'b0;
      out_data_q  <= 64'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      key_q       <= key_d;
      ctr_q       <= ctr_d;
      gen_left_q  <= gen_left_d;
      in_left_q   <= in_left_d;
      ks_q        <= ks_d;
      ks_valid_q  <= ks_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_present_ctr_stream.sv
// Directed + randomized bench for present_ctr_stream against a behavioural PRESENT/CTR model.
module tb_present_ctr_stream;

`ifdef PRESENT_CTR_PREFETCH_EN
  localparam int PERIOD = 33;
`else
  localparam int PERIOD = 35;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [79:0]  key;
  logic [63:0]  iv;
  logic [15:0]  num_blocks;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  logic         b_start;
  logic [127:0] b_key;
  logic [63:0]  b_iv;
  logic [15:0]  b_num;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [63:0]  b_in_data;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [63:0]  b_out_data;
  logic         b_out_last;
  logic         b_busy;
  logic         b_done;

  int           checks = 0;
  int           errors = 0;
  logic [63:0]  got_q [$];
  int           in_cyc [$];

  logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  always #5 clk = ~clk;

  present_ctr_stream #(.KEY_W(80), .CTR_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv), .num_blocks(num_blocks),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  present_ctr_stream #(.KEY_W(128), .CTR_W(64), .CNT_W(16)) u_dut128 (
    .clk(clk), .rst(rst), .start(b_start), .key(b_key), .iv(b_iv), .num_blocks(b_num),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy), .done(b_done)
  );

  // Textbook PRESENT encryption of one block; kw selects the 80- or 128-bit schedule.
  function automatic logic [63:0] present_ref(input logic [63:0] pt, input logic [127:0] k, input int kw);
    logic [127:0] kr;
    logic [63:0]  s;
    logic [63:0]  t;
    kr = k;
    s  = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ ((kw == 128) ? kr[127:64] : kr[79:16]);
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
      t = 64'd0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : ((b * 16) % 63)] = s[b];
      s = t;
      if (kw == 128) begin
        kr = {kr[66:0], kr[127:67]};
        kr[127:124] = SB[kr[127:124]];
        kr[123:120] = SB[kr[123:120]];
        kr[66:62]   = kr[66:62] ^ 5'(r);
      end else begin
        kr[79:0]  = {kr[18:0], kr[79:19]};
        kr[79:76] = SB[kr[79:76]];
        kr[19:15] = kr[19:15] ^ 5'(r);
      end
    end
    return s ^ ((kw == 128) ? kr[127:64] : kr[79:16]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Run a whole message on the 80-bit DUT with random stalls; CTR field is the low 8 bits.
  task automatic stream(input logic [79:0] k, input logic [63:0] v, input int n,
                        input int stall, input bit rnd_data);
    logic [63:0] din [$];
    logic [63:0] exp [$];
    logic [63:0] held;
    bit          hold_chk;
    int          ni;
    int          no;
    int          cyc;
    got_q.delete();
    in_cyc.delete();
    for (int i = 0; i < n; i++) begin
      din.push_back(rnd_data ? {$urandom, $urandom} : 64'd0);
      exp.push_back(din[i] ^ present_ref({v[63:8], v[7:0] + 8'(i)}, {48'd0, k}, 80));
    end
    key = k; iv = v; num_blocks = 16'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; ni = 0; no = 0; hold_chk = 1'b0; held = 64'd0;
    while (no < n && cyc < 3000) begin
      in_valid  = (ni < n) && ($urandom_range(99) >= stall);
      in_data   = (ni < n) ? din[ni] : 64'd0;
      out_ready = ($urandom_range(99) >= stall);
      #1;
      if (hold_chk) begin
        chk1("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, held);
        hold_chk = 1'b0;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        chk($sformatf("data_%0d", no), out_data, exp[no]);
        chk1($sformatf("last_%0d", no), out_last, (no == n - 1));
        no++;
      end else if (out_valid) begin
        held = out_data;
        hold_chk = 1'b1;
      end
      if (in_valid && in_ready) begin
        in_cyc.push_back(cyc);
        ni++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("blocks_out", 64'(no), 64'(n));
    chk1("done_pulse", done, 1'b1);
    chk1("busy_fall", busy, 1'b0);
    @(negedge clk);
    chk1("done_once", done, 1'b0);
  endtask

  task automatic run128(input logic [127:0] k, input logic [63:0] d);
    int c;
    b_key = k; b_iv = 64'd0; b_num = 16'd1; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    c = 1;
    while (!b_in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("k128_in_ready_cycle", 64'(c), 64'd33);
    b_in_valid = 1'b1; b_in_data = d; b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk1("k128_out_valid", b_out_valid, 1'b1);
    chk1("k128_out_last", b_out_last, 1'b1);
    chk("k128_data", b_out_data, d ^ present_ref(64'd0, k, 128));
    got_q.push_back(b_out_data);
    @(negedge clk);
    b_out_ready = 1'b0;
    chk1("k128_done", b_done, 1'b1);
  endtask

  task automatic wait_in_ready(input string tag, input int limit);
    int c;
    c = 0;
    while (!in_ready && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk1(tag, in_ready, 1'b1);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; key = 80'd0; iv = 64'd0; num_blocks = 16'd0;
    in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;
    b_start = 1'b0; b_key = 128'd0; b_iv = 64'd0; b_num = 16'd0;
    b_in_valid = 1'b0; b_in_data = 64'd0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_out_data", out_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single block, key 0 / iv 0, with cycle-exact timing and an output stall.
    key = 80'd0; iv = 64'd0; num_blocks = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("t1_busy_c1", busy, 1'b1);
    chk1("t1_in_ready_c1", in_ready, 1'b0);
    cyc = 1;
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t1_in_ready_cycle", 64'(cyc), 64'd33);
    in_valid = 1'b1; in_data = 64'd0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk1("t1_out_valid_c34", out_valid, 1'b1);
    chk("t1_out_data", out_data, 64'h5579C1387B228445);
    chk1("t1_out_last", out_last, 1'b1);
    chk1("t1_in_ready_drop", in_ready, 1'b0);
    @(negedge clk);
    chk1("t1_stall_valid", out_valid, 1'b1);
    chk("t1_stall_data", out_data, 64'h5579C1387B228445);
    chk1("t1_no_early_done", done, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("t1_done", done, 1'b1);
    chk1("t1_busy_fall", busy, 1'b0);
    chk1("t1_out_valid_fall", out_valid, 1'b0);
    @(negedge clk);
    chk1("t1_done_once", done, 1'b0);

    // Known-answer vectors.
    stream({80{1'b1}}, 64'd0, 1, 0, 1'b0);
    chk("kat_key_ones", got_q[0], 64'hE72C46C0F5945049);
    stream(80'd0, {64{1'b1}}, 1, 0, 1'b0);
    chk("kat_iv_ones", got_q[0], 64'hA112FFC72F68417B);

    // Low counter field wraps from 0xFF to 0x00.
    stream(80'd0, 64'h00000000000000FF, 2, 0, 1'b0);
    chk("wrap_second_block", got_q[1], 64'h5579C1387B228445);

    // Random stalls on both handshakes, upper counter bits random.
    for (int r = 0; r < 3; r++) begin
      stream({16'($urandom), $urandom, $urandom}, {$urandom, $urandom}, 4, 30, 1'b1);
    end

    // Throughput with no stalls.
    stream({16'($urandom), $urandom, $urandom}, {$urandom, $urandom}, 3, 0, 1'b1);
    chk("tput_count", 64'(in_cyc.size()), 64'd3);
    if (in_cyc.size() == 3) begin
      chk("tput_first", 64'(in_cyc[0]), 64'd33);
      chk("tput_gap1", 64'(in_cyc[1] - in_cyc[0]), 64'(PERIOD));
      chk("tput_gap2", 64'(in_cyc[2] - in_cyc[1]), 64'(PERIOD));
    end

    // Reset in the middle of a message, then a clean restart.
    key = 80'd0; iv = 64'd0; num_blocks = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_in_ready("mid_rst_first_ready", 100);
    in_valid = 1'b1; in_data = {$urandom, $urandom}; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk1("mid_rst_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("mid_rst_in_ready", in_ready, 1'b0);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, 64'd0);
    chk1("mid_rst_out_last", out_last, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    stream(80'd0, 64'd0, 1, 0, 1'b0);
    chk("after_rst_data", got_q[0], 64'h5579C1387B228445);

    // Empty message.
    key = 80'd0; iv = 64'd0; num_blocks = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("zero_busy_c1", busy, 1'b1);
    chk1("zero_done_c1", done, 1'b0);
    chk1("zero_in_ready_c1", in_ready, 1'b0);
    @(negedge clk);
    chk1("zero_done_c2", done, 1'b1);
    chk1("zero_busy_c2", busy, 1'b0);
    chk1("zero_in_ready_c2", in_ready, 1'b0);
    @(negedge clk);
    chk1("zero_done_once", done, 1'b0);

    // A second start while busy must not disturb the running message.
    key = 80'd0; iv = 64'd0; num_blocks = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    key = {80{1'b1}}; iv = {64{1'b1}}; num_blocks = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_in_ready("busy_start_ready", 100);
    in_valid = 1'b1; in_data = 64'd0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_start_data", out_data, 64'h5579C1387B228445);
    chk1("busy_start_last", out_last, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    chk1("busy_start_done", done, 1'b1);
    chk1("busy_start_idle", busy, 1'b0);

    // 128-bit key instance.
    got_q.delete();
    run128(128'd0, 64'd0);
    chk("kat_k128_zero", got_q[0], 64'h96DB702A2E6900AF);
    run128({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
